// File: rtl/noc_tx_arbiter.sv
// Round-robin arbiter that shares one NoC output port between N_REQ requesters,
// with a programmable inter-word gap and a small Avalon-MM control/status block.
module noc_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       noc_out,
  output logic                    noc_valid,
  input  logic                    noc_ready,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0] LAST_MAX = 3'(N_REQ - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t              state, state_nx;
  logic                enable;
  logic [N_REQ-1:0]    mask;
  logic [2:0]          last;
  logic [31:0]         count;
  logic [3:0]          gap_cnt;
  logic                wr_en, arb_go, xfer_done;
  logic [N_REQ-1:0]    eligible, rot;
  logic [2*N_REQ-1:0]  elig2;
  logic [2:0]          start, off, win_idx;
  logic [3:0]          win_sum;
  logic [DATA_W-1:0]   win_data;
  logic                wd_unused;

  assign wr_en     = chipselect && !write_n;
  assign eligible  = enable ? (req & ~mask) : '0;
  assign dbg_state = state;
  assign wd_unused = &{1'b0, writedata[31:N_REQ+1], elig2[2*N_REQ-1:N_REQ]};

  // Rotate the eligible set so the search origin (last+1) sits at bit 0, then
  // take the lowest set bit and rotate the offset back to a requester index.
  always_comb begin
    start = (last == LAST_MAX) ? 3'd0 : last + 3'd1;
    elig2 = {eligible, eligible} >> start;
    rot   = elig2[N_REQ-1:0];
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    win_sum = {1'b0, start} + {1'b0, off};
    win_idx = (win_sum > {1'b0, LAST_MAX}) ? 3'(win_sum - 4'(N_REQ)) : win_sum[2:0];
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == 3'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Handshake: noc_valid rises with a new word in noc_out; both hold steady
  // until the first edge with noc_valid && noc_ready, which retires the word.
  always_comb begin
    state_nx  = state;
    arb_go    = 1'b0;
    xfer_done = 1'b0;
    unique case (state)
      IDLE: if (|eligible) begin
        arb_go   = 1'b1;
        state_nx = SEND;
      end
      SEND: if (noc_ready) begin
        xfer_done = 1'b1;
        state_nx  = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: if (gap_cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      enable    <= 1'b0;
      mask      <= '0;
      last      <= LAST_MAX;
      count     <= '0;
      noc_out   <= '0;
      noc_valid <= 1'b0;
      grant     <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= '0;
      if (arb_go) begin
        noc_out   <= win_data;
        noc_valid <= 1'b1;
        grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        last      <= win_idx;
      end
      if (xfer_done) begin
        noc_valid <= 1'b0;
        gap_cnt   <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
      if (wr_en && address == 2'd0) begin
        enable <= writedata[0];
        mask   <= writedata[N_REQ:1];
      end
      // A software clear beats a completing transfer in the same cycle.
      if (wr_en && address == 2'd2) count <= '0;
      else if (xfer_done)           count <= count + 32'd1;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[N_REQ:0] = {mask, enable};
      2'd1: begin
        readdata[0]    = (state != IDLE);
        readdata[10:8] = last;
      end
      2'd2: readdata = count;
      2'd3: readdata[DATA_W-1:0] = noc_out;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Bench for noc_tx_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model and a word scoreboard.
module tb_noc_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [N*32-1:0]   req_data;
  logic [N-1:0]      grant;
  logic [31:0]       noc_out;
  logic              noc_valid;
  logic              noc_ready;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [1:0]        dbg_state;

  noc_tx_arbiter #(.N_REQ(N), .DATA_W(32), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .grant(grant), .noc_out(noc_out), .noc_valid(noc_valid),
    .noc_ready(noc_ready), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic          m_en;
  logic [N-1:0]  m_mask;
  int            m_last;
  logic [31:0]   m_count;
  logic [31:0]   m_out;
  logic          m_valid;
  int            m_gap;
  logic [N-1:0]  m_grant;
  logic [31:0]   exp_q[$];

  logic [31:0]   rdata[N];
  logic          hold_mode;
  int            n_checks = 0;
  int            n_err = 0;
  int            cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic m_busy();
    return m_valid || (m_gap > 0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {27'b0, m_mask, m_en};
      2'd1:    return {21'b0, 3'(m_last), 7'b0, m_busy()};
      2'd2:    return m_count;
      default: return m_out;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_mask = '0; m_last = N - 1; m_count = '0;
    m_out = '0; m_valid = 1'b0; m_gap = 0; m_grant = '0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic         wr;
    logic         found;
    int           idx;
    wr = chipselect && !write_n;
    m_grant = '0;
    if (m_valid) begin
      if (noc_ready) begin
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("sb_word", noc_out, exp_q.pop_front());
        m_valid = 1'b0;
        m_count = m_count + 32'd1;
        m_gap = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_en) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && req[idx] && !m_mask[idx]) begin
          found = 1'b1;
          m_grant[idx] = 1'b1;
          m_out = rdata[idx];
          m_valid = 1'b1;
          m_last = idx;
          exp_q.push_back(rdata[idx]);
        end
      end
    end
    if (wr && address == 2'd0) begin
      m_en = writedata[0];
      m_mask = writedata[N:1];
    end
    if (wr && address == 2'd2) m_count = '0;
  endtask

  task automatic pack_data();
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = rdata[i];
  endtask

  task automatic update_reqs();
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        req[i] = 1'($urandom_range(0, 1));
        rdata[i] = $urandom;
      end else if (!req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        rdata[i] = $urandom;
      end
    end
    pack_data();
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("grant", 32'(grant), 32'(m_grant));
    check("noc_valid", 32'(noc_valid), 32'(m_valid));
    check("noc_out", noc_out, m_out);
    check("busy", 32'(dbg_state != 2'd0), 32'(m_busy()));
    check("readdata", readdata, model_rd(address));
    if (!hold_mode) update_reqs();
  endtask

  task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 40 && idx < 0; c++) begin
      step();
      for (int i = 0; i < N; i++) if (grant[i]) idx = i;
    end
    if (idx < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic hold_all();
    hold_mode = 1'b1;
    req = '1;
    for (int i = 0; i < N; i++) rdata[i] = 32'hA0 + 32'(i);
    pack_data();
  endtask

  initial begin
    int idx;
    int prev;
    int ord1[5] = '{0, 1, 2, 3, 0};
    int ord2[4] = '{0, 2, 3, 0};
    logic [31:0] r;

    reset_n = 1'b0; noc_ready = 1'b0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    hold_all();
    do_reset();

    // Reset values and no grant while disabled
    read_check("rst_ctrl", 2'd0, 32'h0);
    read_check("rst_status", 2'd1, 32'h0000_0300);
    read_check("rst_count", 2'd2, 32'h0);
    read_check("rst_out", 2'd3, 32'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("disabled_grant", 32'(grant), 32'h0);
    end

    // Round-robin over all requesters with a 3-cycle word period
    noc_ready = 1'b1;
    avl_write(2'd0, 32'h1);
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(idx);
      check("rr_order", 32'(idx), 32'(ord1[g]));
      check("rr_word", noc_out, 32'hA0 + 32'(ord1[g]));
      if (g > 0) check("rr_period", 32'(cyc - prev), 32'(2 + GAP));
      prev = cyc;
    end
    avl_write(2'd0, 32'h0);
    read_check("rr_count", 2'd2, 32'd5);

    // Masked requester 1 is skipped; unmasking mid-SEND applies next time
    do_reset();
    hold_all();
    avl_write(2'd0, 32'h5);
    for (int g = 0; g < 4; g++) begin
      wait_grant(idx);
      check("mask_order", 32'(idx), 32'(ord2[g]));
    end
    avl_write(2'd0, 32'h1);
    wait_grant(idx);
    check("unmask_grant", 32'(idx), 32'd1);

    // Back-pressure: word and valid hold, no extra grant, COUNT frozen
    noc_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold_out", noc_out, 32'hA1);
      check("hold_valid", 32'(noc_valid), 32'd1);
      check("hold_grant", 32'(grant), 32'h0);
      read_check("hold_count", 2'd2, 32'd4);
    end
    noc_ready = 1'b1;
    step();
    read_check("ready_count", 2'd2, 32'd5);

    // COUNT wrap, then a clear coincident with a completion
    noc_ready = 1'b0;
    wait_grant(idx);
    check("wrap_grant", 32'(idx), 32'd2);
    force dut.count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    release dut.count;
    read_check("count_pre", 2'd2, 32'hFFFF_FFFF);
    noc_ready = 1'b1;
    step();
    read_check("count_wrap", 2'd2, 32'h0);
    wait_grant(idx);
    avl_write(2'd2, 32'h1234);
    read_check("count_coinc", 2'd2, 32'h0);

    // Reset during SEND drops the word at once
    noc_ready = 1'b0;
    wait_grant(idx);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_valid", 32'(noc_valid), 32'd0);
    check("rst_mid_out", noc_out, 32'h0);
    read_check("rst_mid_count", 2'd2, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    noc_ready = 1'b1;
    avl_write(2'd0, 32'h1);
    wait_grant(idx);
    check("rst_first_grant", 32'(idx), 32'd0);

    // Random traffic against the reference model
    hold_mode = 1'b0;
    for (int c = 0; c < 400; c++) begin
      noc_ready = ($urandom_range(0, 3) != 0);
      address = 2'($urandom_range(0, 3));
      r = 32'($urandom_range(0, 99));
      if (r < 6)
        avl_write(2'd0, {27'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) != 0)});
      else if (r < 8)
        avl_write(2'd2, $urandom);
      else
        step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
